// File: rtl/seg_scan_decoder.sv
// Seven-segment display-bus monitor: decodes one multiplexed digit per beat,
// assembles a scan frame and publishes the word once it is stable.
module seg_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_FRAMES  = 2,
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    seg_valid,
    input  logic [6:0]              seg_in,
    input  logic [2:0]              dig_idx,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    word_valid,
    output logic                    seq_err,
    output logic [1:0]              dbg_state
);

    localparam int          CW         = 6 * NUM_DIGITS;
    localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]  STABLE_TGT = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        WAIT0   = 2'd0,
        COLLECT = 2'd1,
        COMPARE = 2'd2
    } state_t;

    // Record layout per digit: {blank, err, nibble}.
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 6'h00;
            7'b1111001: decode = 6'h01;
            7'b0100100: decode = 6'h02;
            7'b0110000: decode = 6'h03;
            7'b0011001: decode = 6'h04;
            7'b0010010: decode = 6'h05;
            7'b0000010: decode = 6'h06;
            7'b1111000: decode = 6'h07;
            7'b0000000: decode = 6'h08;
            7'b0010000: decode = 6'h09;
            7'b0001000: decode = 6'h0A;
            7'b0000011: decode = 6'h0B;
            7'b1000110: decode = 6'h0C;
            7'b0100001: decode = 6'h0D;
            7'b0000110: decode = 6'h0E;
            7'b0001110: decode = 6'h0F;
            7'b1111111: decode = 6'b100000;
            default:    decode = 6'b010000;
        endcase
    endfunction

    state_t          r_state;
    logic [2:0]      r_expect;
    logic [CW-1:0]   r_cap;
    logic [CW-1:0]   r_shadow;
    logic [CW-1:0]   r_pub;
    logic [3:0]      r_cnt;
    logic            r_pub_pend;
    logic            r_word_valid;
    logic            r_seq_err;

    logic [6:0]      w_seg;
    logic [5:0]      w_rec;
    logic            w_cap_en;
    logic            w_same;
    logic [3:0]      w_cnt_next;
    logic            w_qualify;

    assign w_seg = ACTIVE_LOW_SEG ? seg_in : ~seg_in;
    assign w_rec = decode(w_seg);

    // A beat lands in its slot only when the sequencer will accept it.
    assign w_cap_en = seg_valid &&
                      ((r_state != COLLECT && dig_idx == 3'd0) ||
                       (r_state == COLLECT && (dig_idx == 3'd0 || dig_idx == r_expect)));

    // A zero count means the shadow holds nothing real, even if it matches.
    assign w_same     = (r_cap == r_shadow) && (r_cnt != 4'd0);
    assign w_cnt_next = w_same ? ((r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1) : 4'd1;
    assign w_qualify  = (w_cnt_next == STABLE_TGT) && (!w_same || r_cnt != 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT0;
            r_expect     <= 3'd0;
            r_cap        <= '0;
            r_shadow     <= '0;
            r_pub        <= '0;
            r_cnt        <= 4'd0;
            r_pub_pend   <= 1'b0;
            r_word_valid <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_seq_err    <= 1'b0;
            r_pub_pend   <= 1'b0;

            if (r_pub_pend) begin
                r_pub        <= r_shadow;
                r_word_valid <= 1'b1;
            end

            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (w_cap_en && dig_idx == 3'(k)) begin
                    r_cap[6*k +: 6] <= w_rec;
                end
            end

            if (r_state == COMPARE) begin
                r_cnt      <= w_cnt_next;
                r_pub_pend <= w_qualify;
                if (!w_same) begin
                    r_shadow <= r_cap;
                end
            end

            case (r_state)
                WAIT0, COMPARE: begin
                    r_state <= WAIT0;
                    if (seg_valid && dig_idx == 3'd0) begin
                        r_expect <= 3'd1;
                        r_state  <= (NUM_DIGITS == 1) ? COMPARE : COLLECT;
                    end
                end
                COLLECT: begin
                    if (seg_valid) begin
                        if (dig_idx == 3'd0) begin
                            r_seq_err <= 1'b1;
                            r_expect  <= 3'd1;
                        end else if (dig_idx == r_expect) begin
                            r_expect <= r_expect + 3'd1;
                            if (r_expect == LAST_IDX) begin
                                r_state <= COMPARE;
                            end
                        end else begin
                            r_seq_err <= 1'b1;
                            r_state   <= WAIT0;
                        end
                    end
                end
                default: r_state <= WAIT0;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_unpack
        assign hex_out[4*k +: 4] = r_pub[6*k +: 4];
        assign digit_err[k]      = r_pub[6*k + 4];
        assign digit_blank[k]    = r_pub[6*k + 5];
    end

    assign word_valid = r_word_valid;
    assign seq_err    = r_seq_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: 4 digits, two stable frames to publish,
// plus an active-high-polarity instance fed the complemented bus.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        seg_valid;
    logic [6:0]  seg_in;
    logic [6:0]  seg_in_hi;
    logic [2:0]  dig_idx;

    logic [15:0] hex_out;
    logic [3:0]  digit_err;
    logic [3:0]  digit_blank;
    logic        word_valid;
    logic        seq_err;
    logic [1:0]  dbg_state;

    logic [15:0] hi_hex_out;
    logic [3:0]  hi_digit_err;
    logic [3:0]  hi_digit_blank;
    logic        hi_word_valid;
    logic        hi_seq_err;
    logic [1:0]  hi_dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pub_cnt  = 0;
    int          seq_cnt  = 0;
    logic [15:0] exp_q[$];
    logic [6:0]  enc [16];

    // Active-high display bus carries the complement of the active-low one.
    assign seg_in_hi = ~seg_in;

    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_FRAMES(2), .ACTIVE_LOW_SEG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_in(seg_in), .dig_idx(dig_idx),
        .hex_out(hex_out), .digit_err(digit_err), .digit_blank(digit_blank),
        .word_valid(word_valid), .seq_err(seq_err), .dbg_state(dbg_state)
    );

    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_FRAMES(2), .ACTIVE_LOW_SEG(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_in(seg_in_hi), .dig_idx(dig_idx),
        .hex_out(hi_hex_out), .digit_err(hi_digit_err), .digit_blank(hi_digit_blank),
        .word_valid(hi_word_valid), .seq_err(hi_seq_err), .dbg_state(hi_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: every publish must match the next expected word
    always @(negedge clk) begin
        if (rst_n && word_valid) begin
            pub_cnt++;
            if (exp_q.size() == 0) check("unexpected_publish", {16'h0, hex_out}, 32'hFFFF_FFFF);
            else check("publish_word", {16'h0, hex_out}, {16'h0, exp_q.pop_front()});
        end
        if (rst_n && seq_err) seq_cnt++;
    end

    // drivers
    task automatic send_beat(input logic [2:0] idx, input logic [6:0] pat);
        @(negedge clk);
        seg_valid = 1'b1;
        dig_idx   = idx;
        seg_in    = pat;
    endtask

    task automatic end_beats();
        @(negedge clk);
        seg_valid = 1'b0;
        dig_idx   = 3'd0;
        seg_in    = 7'h7F;
    endtask

    task automatic send_pats(input logic [6:0] p3, input logic [6:0] p2,
                             input logic [6:0] p1, input logic [6:0] p0);
        send_beat(3'd0, p0);
        send_beat(3'd1, p1);
        send_beat(3'd2, p2);
        send_beat(3'd3, p3);
        end_beats();
    endtask

    task automatic send_word(input logic [15:0] w);
        send_pats(enc[w[15:12]], enc[w[11:8]], enc[w[7:4]], enc[w[3:0]]);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int          pub0;
        int          seq0;
        logic [6:0]  pat;
        logic [3:0]  nib;
        logic        is_err;
        logic        is_blank;

        enc[0]  = 7'b1000000; enc[1]  = 7'b1111001; enc[2]  = 7'b0100100; enc[3]  = 7'b0110000;
        enc[4]  = 7'b0011001; enc[5]  = 7'b0010010; enc[6]  = 7'b0000010; enc[7]  = 7'b1111000;
        enc[8]  = 7'b0000000; enc[9]  = 7'b0010000; enc[10] = 7'b0001000; enc[11] = 7'b0000011;
        enc[12] = 7'b1000110; enc[13] = 7'b0100001; enc[14] = 7'b0000110; enc[15] = 7'b0001110;

        rst_n     = 1'b0;
        seg_valid = 1'b0;
        dig_idx   = 3'd0;
        seg_in    = 7'h7F;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_hex", {16'h0, hex_out}, 32'h0);
        check("rst_err", {28'h0, digit_err}, 32'h0);
        check("rst_blank", {28'h0, digit_blank}, 32'h0);
        check("rst_word_valid", {31'h0, word_valid}, 32'h0);
        check("rst_seq_err", {31'h0, seq_err}, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);

        // "1234" twice: publish exactly 2 cycles after the last beat
        send_word(16'h1234);
        settle();
        check("one_frame_no_pub", pub_cnt, 0);
        exp_q.push_back(16'h1234);
        send_word(16'h1234);
        check("lat_cycle1", {31'h0, word_valid}, 32'h0);
        @(negedge clk);
        check("lat_cycle2", {31'h0, word_valid}, 32'h0);
        @(negedge clk);
        check("lat_cycle3", {31'h0, word_valid}, 32'h1);
        check("lat_hex", {16'h0, hex_out}, 32'h1234);
        @(negedge clk);
        check("pulse_one_cycle", {31'h0, word_valid}, 32'h0);
        check("hex_1234_err", {28'h0, digit_err}, 32'h0);
        check("hex_1234_blank", {28'h0, digit_blank}, 32'h0);
        settle();
        check("pub_count_1234", pub_cnt, 1);

        // unchanged word, then a change that must requalify
        send_word(16'h1234);
        settle();
        send_word(16'h1235);
        settle();
        check("no_republish", pub_cnt, 1);
        check("hold_hex", {16'h0, hex_out}, 32'h1234);
        exp_q.push_back(16'h1235);
        send_word(16'h1235);
        settle();
        check("pub_count_1235", pub_cnt, 2);
        check("hex_1235", {16'h0, hex_out}, 32'h1235);

        // digit-0 sweep: 16 codes, all-off, and one unrecognised pattern
        for (int c = 0; c < 18; c++) begin
            pat      = (c < 16) ? enc[c] : ((c == 16) ? 7'b1111111 : 7'b1111110);
            nib      = (c < 16) ? 4'(c) : 4'h0;
            is_blank = (c == 16);
            is_err   = (c == 17);
            pub0     = pub_cnt;
            exp_q.push_back({12'h000, nib});
            send_pats(enc[0], enc[0], enc[0], pat);
            send_pats(enc[0], enc[0], enc[0], pat);
            settle();
            check("sweep_pub", pub_cnt - pub0, 1);
            check("sweep_nibble", {28'h0, hex_out[3:0]}, {28'h0, nib});
            check("sweep_err", {31'h0, digit_err[0]}, {31'h0, is_err});
            check("sweep_blank", {31'h0, digit_blank[0]}, {31'h0, is_blank});
        end

        // out-of-order index abandons the frame
        pub0 = pub_cnt;
        seq0 = seq_cnt;
        send_beat(3'd0, enc[4]);
        send_beat(3'd1, enc[3]);
        send_beat(3'd3, enc[1]);
        end_beats();
        settle();
        check("skip_seq_err", seq_cnt - seq0, 1);
        check("skip_no_pub", pub_cnt - pub0, 0);
        check("skip_state", {30'h0, dbg_state}, 32'h0);

        // restart at index 0 mid-frame, then the frame still counts
        seq0 = seq_cnt;
        send_beat(3'd0, enc[1]);
        send_beat(3'd1, enc[2]);
        send_beat(3'd0, enc[1]);
        send_beat(3'd1, enc[2]);
        send_beat(3'd2, enc[3]);
        send_beat(3'd3, enc[4]);
        end_beats();
        settle();
        check("restart_seq_err", seq_cnt - seq0, 1);
        exp_q.push_back(16'h4321);
        send_word(16'h4321);
        settle();
        check("restart_pub", pub_cnt - pub0, 1);
        check("hex_4321", {16'h0, hex_out}, 32'h4321);

        // reset in the middle of a qualifying frame
        send_word(16'h5678);
        send_beat(3'd0, enc[8]);
        send_beat(3'd1, enc[7]);
        @(negedge clk);
        seg_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("midrst_hex", {16'h0, hex_out}, 32'h0);
        check("midrst_err", {28'h0, digit_err}, 32'h0);
        check("midrst_blank", {28'h0, digit_blank}, 32'h0);
        check("midrst_state", {30'h0, dbg_state}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pub0  = pub_cnt;
        send_beat(3'd2, enc[6]);
        send_beat(3'd3, enc[5]);
        end_beats();
        send_word(16'h5678);
        settle();
        check("postrst_no_pub", pub_cnt - pub0, 0);
        check("postrst_hex_zero", {16'h0, hex_out}, 32'h0);
        exp_q.push_back(16'h5678);
        send_word(16'h5678);
        settle();
        check("postrst_pub", pub_cnt - pub0, 1);
        check("hex_5678", {16'h0, hex_out}, 32'h5678);

        // active-high instance sees complemented patterns for "00AF"
        exp_q.push_back(16'h00AF);
        send_word(16'h00AF);
        send_word(16'h00AF);
        settle();
        check("hi_hex_00af", {16'h0, hi_hex_out}, 32'h00AF);
        check("hi_err_00af", {28'h0, hi_digit_err}, 32'h0);
        check("hi_blank_00af", {28'h0, hi_digit_blank}, 32'h0);
        check("lo_hex_00af", {16'h0, hex_out}, 32'h00AF);

        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
